clock_gen: RTL and testbench
============================

# clock_gen

Parameterised square-wave clock generator driven by a single free-running reference clock. It produces a divided 50 % duty-cycle clock with one-cycle rise and fall strobes and a wrapping count of generated cycles. It is the common timing source for the pulse-shaping blocks, which trigger on its edges or strobes. The default half-period is 12 reference ticks, giving a 24-tick period.

## Interface

Parameters:
- HALF_PERIOD, 12, reference ticks per output half-period; legal range ≥ 1.
- CNT_W, 16, width of the generated-cycle counter.

Ports:
- clock  in  1  reference clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, the generator freezes (counter and output hold).
- clk_out  out  1  divided clock, 50 % duty.
- rise  out  1  one-tick strobe, high in the tick where clk_out becomes 1.
- fall  out  1  one-tick strobe, high in the tick where clk_out becomes 0.
- cycles  out  CNT_W  number of clk_out rising edges since reset, modulo 2^CNT_W.

One clock; reset is synchronous and active-high.

## Operation

- Internal tick counter `tcnt`:
  - width max(1, $clog2(HALF_PERIOD)).
  - counts 0 … HALF_PERIOD-1.
- On each clock edge with enable=1:
  - If tcnt == HALF_PERIOD-1: tcnt←0, clk_out←~clk_out.
  - Otherwise: tcnt←tcnt+1.
- Strobes:
  - rise=1 exactly when clk_out transitions 0→1 (registered alongside clk_out).
  - fall=1 exactly when clk_out transitions 1→0.
  - Otherwise both are 0.
- cycles increments by 1 on every 0→1 transition and wraps from 2^CNT_W-1 to 0.
- enable=0:
  - tcnt, clk_out and cycles hold.
  - rise and fall are 0.
  - On re-enable, counting resumes from the held tcnt; no phase reset.
- Reset (priority over enable) sets:
  - clk_out=0, tcnt=0, rise=0, fall=0, cycles=0.
- Reset asserted mid-phase (clk_out high or low) forces all reset values on the next edge. No strobe is generated by a reset-induced fall of clk_out.
- HALF_PERIOD=1: clk_out toggles every tick (period 2).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing

- Take edge 0 as the first edge with reset=0 and enable=1.
- clk_out first rises at edge HALF_PERIOD-1 (12th tick, index 11, for the default). At that edge:
  - rise=1 for that one tick.
  - cycles becomes 1.
- clk_out falls at edge 2·HALF_PERIOD-1, with fall=1 for that tick.
- From then on the output is strictly periodic: period 2·HALF_PERIOD, high and low phases exactly HALF_PERIOD ticks each.
- Latency: one reference edge from the terminal-count condition to the clk_out/strobe update.
- rise and fall are never high in the same tick.

## Structure

- Shared package `clock_pkg`:
  - default HALF_PERIOD constant (12).
  - default CNT_W (16).
  - helper function for counter width.
- Single module, no sub-modules. The generated-cycle counter is simple enough to stay inline; the optional natural split is `edge_strobe` (registered rise/fall detector) if other blocks reuse it.

## Test plan

- Reset values: hold reset=1 for 3 ticks → clk_out=0, rise=0, fall=0, cycles=0 throughout.
- Default generation: release reset, enable=1 →
  - clk_out rises at tick 11 with rise=1 and cycles=1.
  - falls at tick 23 with fall=1.
  - rises again at tick 35 with cycles=2.
  - period 24 holds over 20 periods.
- Enable freeze: drop enable for 5 ticks mid-high-phase →
  - clk_out, cycles and the phase position hold; strobes stay 0.
  - the high phase totals 12 enabled ticks.
- Reset mid-operation: assert reset while clk_out=1 at tick 17 → next edge clk_out=0, cycles=0, fall=0; restart timing identical to the default case.
- Counter wrap: CNT_W=2 → after 4 rising edges cycles reads 0; it reads 1 at the 5th.
- HALF_PERIOD=1 → clk_out toggles every tick, and rise/fall alternate every tick.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared timing constants and the width helper for the square-wave generator.
package clock_pkg;

  localparam int HALF_PERIOD_DEF = 12;
  localparam int CNT_W_DEF       = 16;

  // Width of a counter that holds 0 .. hp-1. It is never narrower than one bit.
  function automatic int tcnt_width(input int hp);
    return (hp <= 1) ? 1 : $clog2(hp);
  endfunction

endpackage

// File: rtl/clock_gen.sv
// Divided 50% square-wave clock, with one-tick rise/fall strobes and a wrapping
// count of generated rising edges. All outputs come straight from flops.
module clock_gen
  import clock_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cycles
);

  localparam int TW = tcnt_width(HALF_PERIOD);
  localparam logic [TW-1:0] TC = TW'(HALF_PERIOD - 1);

  logic [TW-1:0] tcnt;

  // Tick counter, output phase, strobes and edge count advance together.
  // Each strobe is decided from the current phase, so it appears in the same
  // tick as the clk_out change it reports. A reset clears everything and so
  // produces no strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt    <= '0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      cycles  <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (enable) begin
        if (tcnt == TC) begin
          tcnt    <= '0;
          clk_out <= ~clk_out;
          if (!clk_out) begin
            rise   <= 1'b1;
            cycles <= cycles + CNT_W'(1);
          end else begin
            fall   <= 1'b1;
          end
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen. The bench runs three instances:
// the default build, HALF_PERIOD=1, and CNT_W=2 for the wrap case.
// For every tick, the driver pushes the expected outputs for that tick. The
// expected outputs come from a closed-form model of the enabled-edge count,
// plus hand-computed directed vectors. A negedge monitor pops each expected
// entry and compares it with the outputs.
module tb_clock_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst = 3'b111;
  logic [2:0] en  = 3'b000;

  logic        co0, r0, f0;
  logic [15:0] cy0;
  logic        co1, r1, f1;
  logic [15:0] cy1;
  logic        co2, r2, f2;
  logic [1:0]  cy2;

  clock_gen #(.HALF_PERIOD(12), .CNT_W(16)) u0 (
    .clock(clock), .reset(rst[0]), .enable(en[0]),
    .clk_out(co0), .rise(r0), .fall(f0), .cycles(cy0));
  clock_gen #(.HALF_PERIOD(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(rst[1]), .enable(en[1]),
    .clk_out(co1), .rise(r1), .fall(f1), .cycles(cy1));
  clock_gen #(.HALF_PERIOD(3), .CNT_W(2)) u2 (
    .clock(clock), .reset(rst[2]), .enable(en[2]),
    .clk_out(co2), .rise(r2), .fall(f2), .cycles(cy2));

  typedef struct {
    int    id;
    logic  c;
    logic  r;
    logic  f;
    int    cy;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int hp [3] = '{12, 1, 3};
  int cw [3] = '{16, 16, 2};
  int n  [3] = '{0, 0, 0};   // enabled edges since reset, per instance

  // Closed form: after n enabled edges, k = n/hp toggles have happened.
  // The output is high when k is odd. The number of rising edges is (k+1)/2.
  function automatic exp_t model(input int id, input int nn, input logic strobes, input string tag);
    exp_t e;
    int k;
    k = nn / hp[id];
    e.id  = id;
    e.tag = tag;
    e.c   = k[0];
    e.cy  = ((k + 1) / 2) % (1 << cw[id]);
    e.r   = strobes && (nn > 0) && (nn % hp[id] == 0) && (k % 2 == 1);
    e.f   = strobes && (nn > 0) && (nn % hp[id] == 0) && (k > 0) && (k % 2 == 0);
    return e;
  endfunction

  // One reference tick on instance id. The expectation is pushed after the edge.
  task automatic step(input int id, input logic r, input logic e, input string tag);
    exp_t x;
    rst[id] = r;
    en[id]  = e;
    @(posedge clock);
    if (r) begin
      n[id] = 0;
      x = model(id, 0, 1'b0, tag);
    end else if (e) begin
      n[id] = n[id] + 1;
      x = model(id, n[id], 1'b1, tag);
    end else begin
      x = model(id, n[id], 1'b0, tag);
    end
    sb.push_back(x);
    #1;
  endtask

  // Hand-computed vector for the tick that was just stepped.
  task automatic dir(input int id, input logic c, input logic r, input logic f,
                     input int cy, input string tag);
    exp_t x;
    x.id = id; x.c = c; x.r = r; x.f = f; x.cy = cy; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: compare every pending expectation with the instance it names.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t x;
      logic ac, ar, af;
      int   acy;
      x = sb.pop_front();
      case (x.id)
        0:       begin ac = co0; ar = r0; af = f0; acy = int'(cy0); end
        1:       begin ac = co1; ar = r1; af = f1; acy = int'(cy1); end
        default: begin ac = co2; ar = r2; af = f2; acy = int'(cy2); end
      endcase
      total++;
      if (ac !== x.c || ar !== x.r || af !== x.f || acy != x.cy) begin
        bad++;
        $display("FAIL %s (dut%0d): got clk_out=%b rise=%b fall=%b cycles=%0d, want clk_out=%b rise=%b fall=%b cycles=%0d",
                 x.tag, x.id, ac, ar, af, acy, x.c, x.r, x.f, x.cy);
      end
    end
  end

  initial begin
    #1;
    // Reset values, held for 3 ticks.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, "reset0");
    for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, "reset1");
    for (int i = 0; i < 3; i++) step(2, 1'b1, 1'b0, "reset2");

    // Default generation over 20 periods. Edge index i is tick i after release.
    for (int i = 0; i < 480; i++) begin
      step(0, 1'b0, 1'b1, "default");
      if (i == 10) dir(0, 1'b0, 1'b0, 1'b0, 0, "pre_rise_t10");
      if (i == 11) dir(0, 1'b1, 1'b1, 1'b0, 1, "first_rise_t11");
      if (i == 12) dir(0, 1'b1, 1'b0, 1'b0, 1, "high_t12");
      if (i == 23) dir(0, 1'b0, 1'b0, 1'b1, 1, "first_fall_t23");
      if (i == 35) dir(0, 1'b1, 1'b1, 1'b0, 2, "second_rise_t35");
      if (i == 479) dir(0, 1'b0, 1'b0, 1'b1, 20, "fall_t479");
    end

    // Enable freeze in the high phase. The freeze starts after tick 15, which
    // is the 4th high tick, and lasts 5 ticks. The fall then lands after 8 more
    // enabled ticks.
    step(0, 1'b1, 1'b0, "reset_before_freeze");
    for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, "pre_freeze");
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b0, "freeze");
      dir(0, 1'b1, 1'b0, 1'b0, 1, "freeze_hold");
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 1'b1, "post_freeze");
      if (i == 6) dir(0, 1'b1, 1'b0, 1'b0, 1, "still_high_11_enabled");
      if (i == 7) dir(0, 1'b0, 1'b0, 1'b1, 1, "fall_after_12_enabled");
    end

    // Reset mid-operation: reset is asserted while clk_out=1 at tick 17.
    step(0, 1'b1, 1'b0, "reset_before_midop");
    for (int i = 0; i < 17; i++) step(0, 1'b0, 1'b1, "midop_run");
    step(0, 1'b1, 1'b1, "midop_reset");
    dir(0, 1'b0, 1'b0, 1'b0, 0, "midop_reset_vals");
    for (int i = 0; i < 30; i++) begin
      step(0, 1'b0, 1'b1, "restart");
      if (i == 11) dir(0, 1'b1, 1'b1, 1'b0, 1, "restart_rise_t11");
      if (i == 23) dir(0, 1'b0, 1'b0, 1'b1, 1, "restart_fall_t23");
    end

    // HALF_PERIOD=1: the output toggles every tick, and the strobes alternate.
    for (int i = 0; i < 10; i++) begin
      step(1, 1'b0, 1'b1, "hp1");
      if (i == 0) dir(1, 1'b1, 1'b1, 1'b0, 1, "hp1_t0");
      if (i == 1) dir(1, 1'b0, 1'b0, 1'b1, 1, "hp1_t1");
      if (i == 2) dir(1, 1'b1, 1'b1, 1'b0, 2, "hp1_t2");
    end

    // CNT_W=2 with HALF_PERIOD=3: the rising edges are at ticks 2, 8, 14, 20, 26.
    for (int i = 0; i < 27; i++) begin
      step(2, 1'b0, 1'b1, "wrap");
      if (i == 14) dir(2, 1'b1, 1'b1, 1'b0, 3, "wrap_third");
      if (i == 20) dir(2, 1'b1, 1'b1, 1'b0, 0, "wrap_fourth_zero");
      if (i == 26) dir(2, 1'b1, 1'b1, 1'b0, 1, "wrap_fifth_one");
    end

    @(negedge clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
